// File: rtl/rtc_bus_master.sv
// -----------------------------------------------------------------------------
// rtc_bus_master
//
// Sequencer for the RTC chip's multiplexed 8-bit address/data bus. Each
// accepted request runs one complete register access: an address phase
// (setup / wr_n strobe / hold), a cs_n-high gap, then a data phase that either
// writes wdata or reads the bus into rdata, followed by a one-cycle DONE.
//
// Every output comes straight from a flop. Each output flop is loaded with the
// decode of the state being entered, so it lines up with the state register.
//
// Optional feature (macro RTC_ADDR_CACHE_EN): remembers the address of the
// last completed access. A new request to that same address skips the whole
// address phase and the gap, and goes straight to the data phase.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request pulse, only honoured in IDLE
//   rw      in   1 = read, 0 = write (latched with start)
//   addr    in   RTC register address (latched with start)
//   wdata   in   write data (latched with start)
//   ad_in   in   bus value from the inbound tri-state buffer
//   busy    out  high from the cycle after acceptance through DONE
//   done    out  one-cycle completion pulse
//   rdata   out  last read result
//   ad_out  out  value for the outbound tri-state driver
//   ad_oe   out  outbound driver enable
//   ad_sel  out  0 = address phase, 1 = data phase / idle
//   cs_n    out  chip select, active-low
//   rd_n    out  read strobe, active-low
//   wr_n    out  write strobe, active-low
// -----------------------------------------------------------------------------
module rtc_bus_master #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad_sel,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n
);

  localparam int MAX_SS = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int MAX_HG = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int MAX_T  = (MAX_SS > MAX_HG) ? MAX_SS : MAX_HG;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_STROBE,
    S_A_HOLD,
    S_GAP,
    S_D_SETUP,
    S_D_STROBE,
    S_D_HOLD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       ad_out_q, ad_out_d;
  logic             ad_oe_q, ad_oe_d;
  logic             ad_sel_q, ad_sel_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;

  logic             addr_hit;

  // Counter reload value: a state lasting N cycles leaves when the count hits 0.
  function automatic logic [CNT_W-1:0] load_cnt(input state_t s);
    case (s)
      S_A_SETUP, S_D_SETUP:   return CNT_W'(T_SETUP - 1);
      S_A_STROBE, S_D_STROBE: return CNT_W'(T_STROBE - 1);
      S_A_HOLD, S_D_HOLD:     return CNT_W'(T_HOLD - 1);
      S_GAP:                  return CNT_W'(T_GAP - 1);
      default:                return '0;
    endcase
  endfunction

`ifdef RTC_ADDR_CACHE_EN
  logic       cache_vld_q, cache_vld_d;
  logic [7:0] cache_addr_q, cache_addr_d;

  assign addr_hit = cache_vld_q && (addr == cache_addr_q);

  // The cache takes the address of each access as it completes.
  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    if (state_q == S_DONE) begin
      cache_vld_d  = 1'b1;
      cache_addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= 8'h00;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
    end
  end
`else
  assign addr_hit = 1'b0;
`endif

  // Next state, phase counter, request latch and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if (state_q == S_IDLE) begin
      if (start) begin
        rw_d    = rw;
        addr_d  = addr;
        wdata_d = wdata;
        state_d = addr_hit ? S_D_SETUP : S_A_SETUP;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      case (state_q)
        S_A_SETUP:  state_d = S_A_STROBE;
        S_A_STROBE: state_d = S_A_HOLD;
        S_A_HOLD:   state_d = S_GAP;
        S_GAP:      state_d = S_D_SETUP;
        S_D_SETUP:  state_d = S_D_STROBE;
        S_D_STROBE: state_d = S_D_HOLD;
        S_D_HOLD:   state_d = S_DONE;
        default:    state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = load_cnt(state_d);
    end

    // Sample the bus on the edge that closes the final read-strobe cycle.
    if ((state_q == S_D_STROBE) && (cnt_q == '0) && rw_q) begin
      rdata_d = ad_in;
    end
  end

  // Output decode of the state being entered; registered below.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    cs_n_d   = 1'b1;
    ad_sel_d = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;

    case (state_d)
      S_A_SETUP, S_A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      S_A_STROBE: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = 1'b0;
      end
      S_D_SETUP, S_D_HOLD: begin
        cs_n_d = 1'b0;
        if (!rw_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      S_D_STROBE: begin
        cs_n_d = 1'b0;
        // A read keeps the outbound driver off so the RTC can drive the bus.
        if (rw_d) begin
          rd_n_d = 1'b0;
        end else begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
          wr_n_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      ad_sel_q <= 1'b1;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      ad_sel_q <= ad_sel_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign ad_sel = ad_sel_q;
  assign cs_n   = cs_n_q;
  assign rd_n   = rd_n_q;
  assign wr_n   = wr_n_q;

endmodule
